rcas_arbiter: RTL

//  Shares one external WIDTH-bit ripple-carry add/sub datapath between two requesters.
//  - Round-robin grant; valid/ready handshake on both the request side and the response side.
//  - Operands are held stable on the datapath for SETTLE_CYCLES so the carry chain can settle.
//  - Result is captured into a register and returned to the requester that issued the operation.
//  - Sits between client blocks and the rcas datapath instance; it replaces direct a/b/sel wiring.

---
 rtl/rcas_arbiter_pkg.sv | 26 ++
 rtl/rcas_arbiter_if.sv | 64 ++++++
 rtl/rcas_arbiter_rr_pick2.sv | 20 ++
 rtl/rcas_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/rcas_arbiter_pkg.sv
// Shared definitions for the rcas_arbiter slice: FSM state encodings, operation codes
// and the signed-overflow helper used when RCAS_ARB_OVF_EN is defined.
package rcas_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Overflow is judged from sign bits only; the datapath result is taken as-is.
  function automatic logic signed_ovf(input logic sel, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
    if (sel == OP_ADD) begin
      return (a_msb == b_msb) && (r_msb != a_msb);
    end else if (sel == OP_SUB) begin
      return (a_msb != b_msb) && (r_msb != a_msb);
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/rcas_arbiter_if.sv
// Request, response and datapath bundle for rcas_arbiter.
// The rsp0_ovf/rsp1_ovf members exist only when RCAS_ARB_OVF_EN is defined.
interface rcas_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sel;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sel;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_result;
  logic             rsp0_c_out;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_result;
  logic             rsp1_c_out;
`ifdef RCAS_ARB_OVF_EN
  logic             rsp0_ovf;
  logic             rsp1_ovf;
`endif

  logic [WIDTH-1:0] dp_a;
  logic [WIDTH-1:0] dp_b;
  logic             dp_sel;
  logic [WIDTH-1:0] dp_result;
  logic             dp_c_out;

  modport slave (
`ifdef RCAS_ARB_OVF_EN
    output rsp0_ovf, output rsp1_ovf,
`endif
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_c_out,
    output rsp1_valid, rsp1_result, rsp1_c_out,
    input  rsp0_ready, rsp1_ready,
    output dp_a, dp_b, dp_sel,
    input  dp_result, dp_c_out
  );

  modport master (
`ifdef RCAS_ARB_OVF_EN
    input  rsp0_ovf, input rsp1_ovf,
`endif
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_c_out,
    input  rsp1_valid, rsp1_result, rsp1_c_out,
    output rsp0_ready, rsp1_ready,
    input  dp_a, dp_b, dp_sel,
    output dp_result, dp_c_out
  );

endinterface

// File: rtl/rcas_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: a sole valid requester wins,
// a tie goes to the requester that was not granted last.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] pick
);

  // one-hot pick from the valid pair and grant history
  always_comb begin
    pick = 2'b00;
    case (valid)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_grant ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/rcas_arbiter.sv
// Round-robin arbiter sharing one external ripple-carry add/sub datapath between two
// requesters. Defining RCAS_ARB_OVF_EN adds registered signed-overflow flags per response.
module rcas_arbiter #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  rcas_arbiter_if.slave bus
);
  import rcas_arbiter_pkg::*;

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_next;
  logic             last_grant;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick;
  logic [1:0]       ready;
  logic [1:0]       accept;
  logic             capture;
  logic             rsp_done;
  logic             owner_rsp_ready;

  rr_pick2 u_pick (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant),
    .pick       (pick)
  );

  assign bus.req0_ready  = ready[0];
  assign bus.req1_ready  = ready[1];
  // the non-owner's rsp_ready never reaches the FSM
  assign owner_rsp_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;

`ifdef RCAS_ARB_OVF_EN
  logic ovf;
  assign ovf = signed_ovf(bus.dp_sel, bus.dp_a[WIDTH-1], bus.dp_b[WIDTH-1],
                          bus.dp_result[WIDTH-1]);
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // next-state and handshake decode
  always_comb begin
    state_next = state;
    ready      = 2'b00;
    accept     = 2'b00;
    capture    = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        ready  = pick;
        accept = pick & {bus.req1_valid, bus.req0_valid};
        if (accept != 2'b00) begin
          state_next = ST_EXEC;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt == CNT_ONE) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_RESP: begin
        if (owner_rsp_ready) begin
          rsp_done   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_RESP;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // operand launch, grant history and settle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dp_a   <= {WIDTH{1'b0}};
      bus.dp_b   <= {WIDTH{1'b0}};
      bus.dp_sel <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= {CNT_W{1'b0}};
    end else if (accept != 2'b00) begin
      if (accept[1]) begin
        bus.dp_a   <= bus.req1_a;
        bus.dp_b   <= bus.req1_b;
        bus.dp_sel <= bus.req1_sel;
      end else begin
        bus.dp_a   <= bus.req0_a;
        bus.dp_b   <= bus.req0_b;
        bus.dp_sel <= bus.req0_sel;
      end
      owner      <= accept[1];
      last_grant <= accept[1];
      cnt        <= CNT_LOAD;
    end else if (state == ST_EXEC) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  // result capture into the owner's response registers and response handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp0_valid  <= 1'b0;
      bus.rsp0_result <= {WIDTH{1'b0}};
      bus.rsp0_c_out  <= 1'b0;
      bus.rsp1_valid  <= 1'b0;
      bus.rsp1_result <= {WIDTH{1'b0}};
      bus.rsp1_c_out  <= 1'b0;
`ifdef RCAS_ARB_OVF_EN
      bus.rsp0_ovf    <= 1'b0;
      bus.rsp1_ovf    <= 1'b0;
`endif
    end else if (capture) begin
      if (owner) begin
        bus.rsp1_valid  <= 1'b1;
        bus.rsp1_result <= bus.dp_result;
        bus.rsp1_c_out  <= bus.dp_c_out;
`ifdef RCAS_ARB_OVF_EN
        bus.rsp1_ovf    <= ovf;
`endif
      end else begin
        bus.rsp0_valid  <= 1'b1;
        bus.rsp0_result <= bus.dp_result;
        bus.rsp0_c_out  <= bus.dp_c_out;
`ifdef RCAS_ARB_OVF_EN
        bus.rsp0_ovf    <= ovf;
`endif
      end
    end else if (rsp_done) begin
      if (owner) begin
        bus.rsp1_valid <= 1'b0;
      end else begin
        bus.rsp0_valid <= 1'b0;
      end
    end
  end

endmodule
